// File: rtl/vertical_conv.sv
// Vertical pass of the separable Gaussian blur: cascaded line buffers feed a
// 5-tap or 11-tap binomial column filter, normalised back to 8-bit pixels.
module vertical_conv #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        toggle,
  input  logic        frame_start,
  input  logic        valid_in,
  input  logic [17:0] pixel_in_horiz,
  output logic [7:0]  pixel_out,
  output logic        valid_out
);

  localparam int DATA_W = 18;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 28;
  localparam int NLB    = 10;
  localparam int CW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic                r_mode;
  logic [DATA_W-1:0]   r_lb [NLB][IMG_WIDTH];

  logic [ACC_W-1:0]    r_sum_p1;
  logic                r_mode_p1;
  logic                r_vld_p1;

  logic                w_start;
  logic                w_accept;
  logic [CW-1:0]       w_col;
  logic [RW-1:0]       w_row;
  logic                w_mode;
  logic                w_last_col;
  logic                w_last_row;
  logic [RW-1:0]       w_thresh;
  logic                w_qual;
  logic [DATA_W-1:0]   w_tap [NLB+1];
  logic [ACC_W-1:0]    w_sum;

  function automatic logic [COEF_W-1:0] coef(input logic m, input int k);
    logic [COEF_W-1:0] c;
    c = '0;
    if (!m) begin
      case (k)
        0, 4:    c = 8'd1;
        1, 3:    c = 8'd4;
        2:       c = 8'd6;
        default: c = 8'd0;
      endcase
    end else begin
      case (k)
        0, 10:   c = 8'd1;
        1, 9:    c = 8'd10;
        2, 8:    c = 8'd45;
        3, 7:    c = 8'd120;
        4, 6:    c = 8'd210;
        5:       c = 8'd252;
        default: c = 8'd0;
      endcase
    end
    return c;
  endfunction

  // One extra bit so the rounding constant cannot wrap a near-full accumulator.
  function automatic logic [7:0] round_sat(input logic [ACC_W-1:0] s, input logic m);
    logic [ACC_W:0] t;
    logic [ACC_W:0] q;
    if (m) begin
      t = {1'b0, s} + (ACC_W+1)'(524288);
      q = t >> 20;
    end else begin
      t = {1'b0, s} + (ACC_W+1)'(128);
      q = t >> 8;
    end
    return (|q[ACC_W:8]) ? 8'hFF : q[7:0];
  endfunction

  // A frame_start pixel is taken as (0,0) regardless of where the counters are.
  assign w_start    = valid_in && frame_start;
  assign w_accept   = !reset && valid_in && (w_start || (r_state == ACTIVE));
  assign w_col      = w_start ? '0 : r_col;
  assign w_row      = w_start ? '0 : r_row;
  assign w_mode     = w_start ? toggle : r_mode;
  assign w_last_col = (w_col == CW'(IMG_WIDTH - 1));
  assign w_last_row = (w_row == RW'(IMG_HEIGHT - 1));
  assign w_thresh   = w_mode ? RW'(10) : RW'(4);
  assign w_qual     = w_accept && (w_row >= w_thresh);

  always_comb begin
    w_tap[0] = pixel_in_horiz;
    for (int k = 1; k <= NLB; k++) begin
      w_tap[k] = r_lb[k-1][w_col];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k <= NLB; k++) begin
      w_sum = w_sum + ACC_W'(w_tap[k]) * ACC_W'(coef(w_mode, k));
    end
  end

  // Stage 1: line buffer shift and weighted column sum
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sum_p1  <= w_sum;
      r_mode_p1 <= w_mode;
      r_lb[0][w_col] <= pixel_in_horiz;
      for (int i = 1; i < NLB; i++) begin
        r_lb[i][w_col] <= r_lb[i-1][w_col];
      end
    end
  end

  // Stage 2: normalise and register the output pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_mode    <= 1'b0;
      r_vld_p1  <= 1'b0;
      valid_out <= 1'b0;
      pixel_out <= 8'd0;
    end else begin
      r_vld_p1  <= w_qual;
      valid_out <= r_vld_p1;
      if (r_vld_p1) begin
        pixel_out <= round_sat(r_sum_p1, r_mode_p1);
      end
      if (w_accept) begin
        r_mode <= w_mode;
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row   <= '0;
            r_state <= IDLE;
          end else begin
            r_row   <= w_row + 1'b1;
            r_state <= ACTIVE;
          end
        end else begin
          r_col   <= w_col + 1'b1;
          r_row   <= w_row;
          r_state <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vertical_conv.sv
// Self-checking bench for vertical_conv: frame-level reference model, per-cycle
// output scoreboard and directed checks on the scenarios of interest.
module tb_vertical_conv;
  localparam int W = 8;
  localparam int H = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        toggle;
  logic        frame_start;
  logic        valid_in;
  logic [17:0] pixel_in_horiz;
  logic [7:0]  pixel_out;
  logic        valid_out;

  vertical_conv #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .toggle(toggle), .frame_start(frame_start),
    .valid_in(valid_in), .pixel_in_horiz(pixel_in_horiz),
    .pixel_out(pixel_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int cyc; int row; int col; int val;} exp_t;
  exp_t expq[$];

  int tests = 0;
  int fails = 0;
  int nout = 0;
  bit chk_en = 1'b0;
  int obs[H][W];
  int obs_ref[H][W];
  int fr[H][W];
  int img[H][W];
  bit m_active = 1'b0;
  int m_row = 0;
  int m_col = 0;
  bit m_mode = 1'b0;
  int w5[5]   = '{1, 4, 6, 4, 1};
  int w11[11] = '{1, 10, 45, 120, 210, 252, 210, 120, 45, 10, 1};
  int imp[5]  = '{16, 64, 96, 64, 16};

  // Output (r,c) is the binomial-weighted sum of rows r..r-T+1 at column c.
  function automatic int ref_pixel(int r, int c, bit m);
    longint s = 0;
    longint q;
    if (!m) begin
      for (int k = 0; k < 5; k++) s += longint'(w5[k]) * img[r-k][c];
      q = (s + 128) / 256;
    end else begin
      for (int k = 0; k < 11; k++) s += longint'(w11[k]) * img[r-k][c];
      q = (s + 524288) / 1048576;
    end
    return (q > 255) ? 255 : int'(q);
  endfunction

  task automatic model(input bit rs, input bit v, input bit fs, input bit tg, input int px);
    exp_t e;
    int taps;
    if (rs) begin
      m_active = 0; m_row = 0; m_col = 0; m_mode = 0;
      while (expq.size() > 0 && expq[expq.size()-1].cyc > cyc) void'(expq.pop_back());
    end else if (v && (fs || m_active)) begin
      if (fs) begin m_row = 0; m_col = 0; m_mode = tg; m_active = 1; end
      img[m_row][m_col] = px;
      taps = m_mode ? 11 : 5;
      if (m_row >= taps - 1) begin
        e.cyc = cyc + 2; e.row = m_row; e.col = m_col;
        e.val = ref_pixel(m_row, m_col, m_mode);
        expq.push_back(e);
      end
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        if (m_row == H - 1) begin m_row = 0; m_active = 0; end
        else m_row++;
      end
    end
  endtask

  task automatic drive(input bit rs, input bit v, input bit fs, input bit tg, input int px);
    reset = rs; valid_in = v; frame_start = fs; toggle = tg;
    pixel_in_horiz = 18'(px);
    model(rs, v, fs, tg, px);
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic clear_obs();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) obs[r][c] = -1;
    nout = 0;
  endtask

  task automatic send_frame(input bit tg, input int npix, input int gap_pct, input bit flip);
    int r, c;
    bit t;
    for (int i = 0; i < npix; i++) begin
      r = i / W; c = i % W;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        for (int g = 0; g <= $urandom_range(2); g++)
          drive(0, 0, 0, flip ? bit'($urandom) : tg, int'($urandom_range(262143)));
      end
      t = (i == 0) ? tg : (flip ? bit'($urandom) : tg);
      drive(0, 1, (i == 0), t, fr[r][c]);
    end
  endtask

  task automatic drain();
    repeat (5) drive(0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        tests++;
        assert (valid_out === 1'b1 && pixel_out === 8'(expq[0].val)) else begin
          fails++;
          $error("FAIL out r%0d c%0d: observed vld=%b px=%0d, expected vld=1 px=%0d",
                 expq[0].row, expq[0].col, valid_out, pixel_out, expq[0].val);
        end
        obs[expq[0].row][expq[0].col] = int'(pixel_out);
        nout++;
        void'(expq.pop_front());
      end else begin
        tests++;
        assert (valid_out === 1'b0) else begin
          fails++;
          $error("FAIL idle_vld cyc%0d: observed vld=%b, expected 0", cyc, valid_out);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nref;
    reset = 1; valid_in = 0; frame_start = 0; toggle = 0; pixel_in_horiz = '0;
    @(posedge clk); #1;
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_pixel_out", int'(pixel_out), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk_en = 1;

    // Constant 4080, 5-tap
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = 4080;
    clear_obs(); send_frame(0, W*H, 0, 0); drain();
    chk("c5_count", nout, 64);
    n = 0;
    for (int r = 4; r < H; r++) for (int c = 0; c < W; c++) if (obs[r][c] == 255) n++;
    chk("c5_all255", n, 64);
    chk("c5_row3_none", obs[3][7], -1);

    // Constant 261120, 11-tap
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = 261120;
    clear_obs(); send_frame(1, W*H, 0, 0); drain();
    chk("c11_count", nout, 16);
    chk("c11_first", obs[10][0], 255);
    chk("c11_last", obs[11][7], 255);
    chk("c11_row9_none", obs[9][0], -1);

    // Constant 1600, 5-tap
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = 1600;
    clear_obs(); send_frame(0, W*H, 0, 0); drain();
    chk("c1600_count", nout, 64);
    chk("c1600_first", obs[4][0], 100);
    chk("c1600_last", obs[11][7], 100);

    // Impulse at row 4, col 3
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = 0;
    fr[4][3] = 4080;
    clear_obs(); send_frame(0, W*H, 0, 0); drain();
    for (int k = 0; k < 5; k++) chk($sformatf("imp_r%0d", 4 + k), obs[4+k][3], imp[k]);
    chk("imp_r9", obs[9][3], 0);
    chk("imp_neighbour", obs[6][2], 0);

    // Random frame gap-free, then with stalls and toggle noise
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = int'($urandom_range(4080));
    clear_obs(); send_frame(0, W*H, 0, 0); drain();
    obs_ref = obs; nref = nout;
    clear_obs(); send_frame(0, W*H, 35, 1); drain();
    chk("stall_count", nout, nref);
    n = 0;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) if (obs[r][c] != obs_ref[r][c]) n++;
    chk("stall_values_differ", n, 0);

    // Reset at row 6, then unframed pixels, then reset colliding with frame_start
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = int'($urandom_range(4080));
    clear_obs(); send_frame(0, 6*W + 3, 0, 0);
    drive(1, 1, 0, 0, 123);
    chk("rst_mid_vld", int'(valid_out), 0);
    n = nout;
    for (int i = 0; i < 2*W; i++) drive(0, 1, 0, 0, int'($urandom_range(4080)));
    drive(1, 1, 1, 0, 77);
    for (int i = 0; i < W; i++) drive(0, 1, 0, 0, int'($urandom_range(4080)));
    drain();
    chk("rst_no_output", nout, n);

    // Restart with frame_start while ACTIVE
    send_frame(0, 2*W + 3, 0, 0);
    clear_obs(); send_frame(0, W*H, 0, 0); drain();
    chk("restart_count", nout, 64);
    chk("restart_row3_none", obs[3][0], -1);
    chk("restart_row4_out", int'(obs[4][0] >= 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
